// File: rtl/bsg_manycore_pkg.sv
// Shared manycore address layouts and NPA classification type.
// EVA struct field widths are fixed by the 32-bit EVA map, independent of machine size.
package bsg_manycore_pkg;

  localparam int max_x_cord_width_gp               = 7;
  localparam int max_y_cord_width_gp               = 7;
  localparam int global_epa_word_addr_width_gp     = 14;
  localparam int tile_group_epa_word_addr_width_gp = 16;
  localparam int max_tile_group_x_cord_width_gp    = 6;
  localparam int max_tile_group_y_cord_width_gp    = 5;

  typedef struct packed {
    logic [1:0]                                 remote;
    logic [max_y_cord_width_gp-1:0]             y_cord;
    logic [max_x_cord_width_gp-1:0]             x_cord;
    logic [global_epa_word_addr_width_gp-1:0]   addr;
    logic [1:0]                                 low_bits;
  } global_addr_s;

  typedef struct packed {
    logic [2:0]                                    remote;
    logic [max_tile_group_y_cord_width_gp-1:0]     y_cord;
    logic [max_tile_group_x_cord_width_gp-1:0]     x_cord;
    logic [tile_group_epa_word_addr_width_gp-1:0]  addr;
    logic [1:0]                                    low_bits;
  } tile_group_addr_s;

  typedef enum logic [1:0] {
    e_npa_dram,
    e_npa_tile_group,
    e_npa_global,
    e_npa_invalid
  } npa_class_e;

  // True when val is representable in width bits.
  function automatic logic fits_width(input logic [63:0] val, input int unsigned width);
    return (width >= 64) || ((val >> width) == 64'd0);
  endfunction

endpackage

// File: rtl/bsg_manycore_dram_hash_inverse.sv
// Combinational inverse of the DRAM hash: detects a vcache NPA (north or south of the own
// pod) and rebuilds the striped DRAM word index.
module bsg_manycore_dram_hash_inverse
  import bsg_manycore_pkg::*;
#(
  parameter int addr_width_p                 = 28,
  parameter int x_cord_width_p               = 7,
  parameter int y_cord_width_p               = 7,
  parameter int pod_x_cord_width_p           = 3,
  parameter int pod_y_cord_width_p           = 4,
  parameter int num_tiles_x_p                = 16,
  parameter int num_tiles_y_p                = 8,
  parameter int vcache_block_size_in_words_p = 8
) (
  input  logic [x_cord_width_p-1:0]     x_cord,
  input  logic [y_cord_width_p-1:0]     y_cord,
  input  logic [addr_width_p-1:0]       epa,
  input  logic [pod_x_cord_width_p-1:0] pod_x,
  input  logic [pod_y_cord_width_p-1:0] pod_y,
  output logic                          dram_v,
  output logic [28:0]                   word_index
);

  localparam int x_sub_width_lp = (num_tiles_x_p == 1) ? 1 : $clog2(num_tiles_x_p);
  localparam int y_sub_width_lp = (num_tiles_y_p == 1) ? 1 : $clog2(num_tiles_y_p);
  localparam int block_width_lp = $clog2(vcache_block_size_in_words_p);
  localparam int index_width_lp = addr_width_p + 1 + x_sub_width_lp;

  logic [pod_x_cord_width_p-1:0] npa_pod_x;
  logic [pod_y_cord_width_p-1:0] npa_pod_y, pod_y_north, pod_y_south;
  logic [x_sub_width_lp-1:0]     x_sub;
  logic [y_sub_width_lp-1:0]     y_sub;
  logic                          north, south;
  logic [index_width_lp-1:0]     index_full;

  assign x_sub     = x_cord[x_sub_width_lp-1:0];
  assign npa_pod_x = x_cord[x_sub_width_lp +: pod_x_cord_width_p];
  assign y_sub     = y_cord[y_sub_width_lp-1:0];
  assign npa_pod_y = y_cord[y_sub_width_lp +: pod_y_cord_width_p];

  // Neighbouring pod rows wrap within the pod_y field.
  assign pod_y_north = pod_y - pod_y_cord_width_p'(1);
  assign pod_y_south = pod_y + pod_y_cord_width_p'(1);

  assign north  = (npa_pod_y == pod_y_north) & (&y_sub);
  assign south  = (npa_pod_y == pod_y_south) & (y_sub == '0);
  assign dram_v = (npa_pod_x == pod_x) & (north | south);

  assign index_full = {epa[addr_width_p-1:block_width_lp], south, x_sub,
                       epa[block_width_lp-1:0]};

  if (index_width_lp >= 29) begin : g_trunc
    logic unused_index_bits;
    assign word_index        = index_full[28:0];
    assign unused_index_bits = ^index_full;
  end else begin : g_pad
    assign word_index = {{(29-index_width_lp){1'b0}}, index_full};
  end

endmodule

// File: rtl/bsg_manycore_npa_to_eva.sv
// Two-stage NPA -> EVA converter with valid/ready handshakes and a saturating counter of
// consumed NPAs that have no EVA.
module bsg_manycore_npa_to_eva
  import bsg_manycore_pkg::*;
#(
  parameter int data_width_p                 = 32,
  parameter int addr_width_p                 = 28,
  parameter int x_cord_width_p               = 7,
  parameter int y_cord_width_p               = 7,
  parameter int pod_x_cord_width_p           = 3,
  parameter int pod_y_cord_width_p           = 4,
  parameter int num_tiles_x_p                = 16,
  parameter int num_tiles_y_p                = 8,
  parameter int vcache_block_size_in_words_p = 8,
  parameter int invalid_ctr_width_p          = 16,
  localparam int x_sub_width_lp = (num_tiles_x_p == 1) ? 1 : $clog2(num_tiles_x_p),
  localparam int y_sub_width_lp = (num_tiles_y_p == 1) ? 1 : $clog2(num_tiles_y_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  output logic                           ready_o,
  input  logic [x_cord_width_p-1:0]      x_cord_i,
  input  logic [y_cord_width_p-1:0]      y_cord_i,
  input  logic [addr_width_p-1:0]        epa_i,
  input  logic [x_sub_width_lp-1:0]      tgo_x_i,
  input  logic [y_sub_width_lp-1:0]      tgo_y_i,
  input  logic [pod_x_cord_width_p-1:0]  pod_x_i,
  input  logic [pod_y_cord_width_p-1:0]  pod_y_i,
  output logic                           v_o,
  input  logic                           yumi_i,
  output logic [data_width_p-1:0]        eva_o,
  output logic                           is_invalid_addr_o,
  output logic [invalid_ctr_width_p-1:0] invalid_count_o
);

  logic                     dram_v;
  logic [28:0]              dram_index;
  npa_class_e               in_class;

  logic                     s0_v_q, s1_v_q, s1_en;
  npa_class_e               s0_class_q;
  logic [x_cord_width_p-1:0] s0_x_q;
  logic [y_cord_width_p-1:0] s0_y_q;
  logic [addr_width_p-1:0]  s0_epa_q;
  logic [x_sub_width_lp-1:0] s0_tgo_x_q, tg_x_diff;
  logic [y_sub_width_lp-1:0] s0_tgo_y_q, tg_y_diff;
  logic [28:0]              s0_index_q;

  logic [31:0]              eva_n;
  logic                     inv_n;
  tile_group_addr_s         tg_addr;
  global_addr_s             g_addr;
  logic [data_width_p-1:0]  s1_eva_q;
  logic                     s1_inv_q;
  logic [invalid_ctr_width_p-1:0] invalid_count_q;
  logic                     unused_epa_bits;

  bsg_manycore_dram_hash_inverse #(
    .addr_width_p                 (addr_width_p),
    .x_cord_width_p               (x_cord_width_p),
    .y_cord_width_p               (y_cord_width_p),
    .pod_x_cord_width_p           (pod_x_cord_width_p),
    .pod_y_cord_width_p           (pod_y_cord_width_p),
    .num_tiles_x_p                (num_tiles_x_p),
    .num_tiles_y_p                (num_tiles_y_p),
    .vcache_block_size_in_words_p (vcache_block_size_in_words_p)
  ) u_dram_inv (
    .x_cord     (x_cord_i),
    .y_cord     (y_cord_i),
    .epa        (epa_i),
    .pod_x      (pod_x_i),
    .pod_y      (pod_y_i),
    .dram_v     (dram_v),
    .word_index (dram_index)
  );

  // First-match priority: DRAM, own-pod tile group, global, otherwise invalid.
  always_comb begin
    in_class = e_npa_invalid;
    if (dram_v) begin
      in_class = e_npa_dram;
    end else if ((x_cord_i[x_sub_width_lp +: pod_x_cord_width_p] == pod_x_i)
              && (y_cord_i[y_sub_width_lp +: pod_y_cord_width_p] == pod_y_i)
              && fits_width(64'(epa_i), tile_group_epa_word_addr_width_gp)) begin
      in_class = e_npa_tile_group;
    end else if (fits_width(64'(x_cord_i), max_x_cord_width_gp)
              && fits_width(64'(y_cord_i), max_y_cord_width_gp)
              && fits_width(64'(epa_i), global_epa_word_addr_width_gp)) begin
      in_class = e_npa_global;
    end
  end

  assign s1_en   = ~s1_v_q | yumi_i;
  assign ready_o = ~s0_v_q | ~s1_v_q | yumi_i;

  assign tg_x_diff = s0_x_q[x_sub_width_lp-1:0] - s0_tgo_x_q;
  assign tg_y_diff = s0_y_q[y_sub_width_lp-1:0] - s0_tgo_y_q;
  assign unused_epa_bits = ^s0_epa_q;

  always_comb begin
    tg_addr          = '0;
    tg_addr.remote   = 3'b001;
    tg_addr.y_cord   = max_tile_group_y_cord_width_gp'(tg_y_diff);
    tg_addr.x_cord   = max_tile_group_x_cord_width_gp'(tg_x_diff);
    tg_addr.addr     = tile_group_epa_word_addr_width_gp'(s0_epa_q);
    g_addr           = '0;
    g_addr.remote    = 2'b01;
    g_addr.y_cord    = max_y_cord_width_gp'(s0_y_q);
    g_addr.x_cord    = max_x_cord_width_gp'(s0_x_q);
    g_addr.addr      = global_epa_word_addr_width_gp'(s0_epa_q);
    eva_n            = '0;
    inv_n            = 1'b0;
    case (s0_class_q)
      e_npa_dram:       eva_n = {1'b1, s0_index_q, 2'b00};
      e_npa_tile_group: eva_n = tg_addr;
      e_npa_global:     eva_n = g_addr;
      default:          inv_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s0_v_q          <= 1'b0;
      s0_class_q      <= e_npa_invalid;
      s0_x_q          <= '0;
      s0_y_q          <= '0;
      s0_epa_q        <= '0;
      s0_tgo_x_q      <= '0;
      s0_tgo_y_q      <= '0;
      s0_index_q      <= '0;
      s1_v_q          <= 1'b0;
      s1_eva_q        <= '0;
      s1_inv_q        <= 1'b0;
      invalid_count_q <= '0;
    end else begin
      if (ready_o) begin
        s0_v_q <= v_i;
        if (v_i) begin
          s0_class_q <= in_class;
          s0_x_q     <= x_cord_i;
          s0_y_q     <= y_cord_i;
          s0_epa_q   <= epa_i;
          s0_tgo_x_q <= tgo_x_i;
          s0_tgo_y_q <= tgo_y_i;
          s0_index_q <= dram_index;
        end
      end
      if (s1_en) begin
        s1_v_q <= s0_v_q;
        if (s0_v_q) begin
          s1_eva_q <= data_width_p'(eva_n);
          s1_inv_q <= inv_n;
        end
      end
      if (s1_v_q & yumi_i & s1_inv_q & ~(&invalid_count_q)) begin
        invalid_count_q <= invalid_count_q + invalid_ctr_width_p'(1);
      end
    end
  end

  assign v_o               = s1_v_q;
  assign eva_o             = s1_eva_q;
  assign is_invalid_addr_o = s1_inv_q;
  assign invalid_count_o   = invalid_count_q;

endmodule

// File: doc/bsg_manycore_npa_to_eva.md
# bsg_manycore_npa_to_eva

Pipelined converter from Network Physical Address (NPA: x/y-cord + EPA word address) back to a 32-bit byte-addressed Endpoint Virtual Address (EVA). It is the inverse of the EVA→NPA mapping for all three universal spaces: DRAM, Global and Tile-Group. Consumers are the host link, trace/profiler units and remote-load-response tagging, which receive NPAs and must report or replay them as EVAs. Input and output use valid/ready handshakes; a sticky counter tallies NPAs that have no EVA.

## Interface
Parameters:
- data_width_p, none, EVA width; must be 32
- addr_width_p, none, EPA word-address width
- x_cord_width_p / y_cord_width_p, none, global cord widths
- pod_x_cord_width_p / pod_y_cord_width_p, none, pod cord widths
- num_tiles_x_p / num_tiles_y_p, none, tiles per pod; subcord widths are the safe clog2 of each
- vcache_block_size_in_words_p, none, DRAM striping granularity
- invalid_ctr_width_p, 16, width of the invalid counter

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- v_i  in  1  input NPA valid
- ready_o  out  1  input accepted when v_i & ready_o
- x_cord_i  in  x_cord_width_p  NPA x
- y_cord_i  in  y_cord_width_p  NPA y
- epa_i  in  addr_width_p  NPA word address
- tgo_x_i / tgo_y_i  in  x/y subcord width  tile-group origin; sampled at input handshake
- pod_x_i / pod_y_i  in  pod widths  own pod; sampled at input handshake
- v_o  out  1  output valid
- yumi_i  in  1  consumer takes output; legal only while v_o
- eva_o  out  32  byte-addressed EVA
- is_invalid_addr_o  out  1  NPA had no EVA; eva_o is 0
- invalid_count_o  out  invalid_ctr_width_p  saturating count of invalid outputs consumed

## Operation
- Split each cord into pod and subcord: y_cord = {pod_y, y_sub}, x_cord = {pod_x, x_sub}.
- Classification uses first-match priority:
  1. DRAM. Requires pod_x == pod_x_i, and one of:
     - north: pod_y == pod_y_i−1 and y_sub is all ones
     - south: pod_y == pod_y_i+1 and y_sub == 0
     - Word index = {epa[addr_width_p−1:b], south, x_sub, epa[b−1:0]}, where b = clog2(vcache_block_size_in_words_p).
     - eva_o = {1'b1, word_index[28:0], 2'b00}. Upper bits are truncated.
  2. Tile-group. Requires pod_x == pod_x_i, pod_y == pod_y_i, and epa < 2^tile_group_epa_word_addr_width_gp.
     - x field = x_sub − tgo_x (mod 2^x_sub width); y field = y_sub − tgo_y (mod 2^y_sub width).
     - Pack into tile_group_addr_s with remote=3'b001 and low bits 00.
  3. Global. Requires x_cord and y_cord to fit the global struct fields, and epa < 2^global_epa_word_addr_width_gp.
     - Pack into global_addr_s with remote=2'b01 and low bits 00.
  4. Otherwise invalid: eva_o=0, is_invalid_addr_o=1.
- Subtraction is pure modular; pod_y_i±1 also wraps within pod_y width.
- Stage 0 registers the inputs and the class. Stage 1 registers eva_o and is_invalid_addr_o.
- invalid_count_o increments on v_o & yumi_i & is_invalid_addr_o, and holds at all ones.

## Timing
- Reset values: v_o=0, eva_o=0, is_invalid_addr_o=0, invalid_count_o=0, both stages empty, ready_o=1.
- Latency: an input accepted at cycle t appears on v_o at t+2 if the pipeline is not stalled.
- Throughput is one NPA per cycle while yumi_i is held high.
- Stall rules:
  - Stage 1 holds while v_o & ~yumi_i.
  - Stage 0 advances when stage 1 is empty or yumi_i is high.
  - ready_o = ~s0_v | ~s1_v | yumi_i. It is combinational from yumi_i, with no path from v_i.
- A simultaneous accept and yumi_i on a full pipeline keeps the pipe full with no bubble and no loss.
- Output fields are stable while v_o & ~yumi_i.
- tgo and pod inputs may change at any time; only the values sampled at handshake are used.
- Reset asserted mid-operation discards both stages and clears the counter immediately (asynchronous).

## Structure
- bsg_manycore_pkg already holds global_addr_s, tile_group_addr_s, global_epa_word_addr_width_gp and tile_group_epa_word_addr_width_gp. Reuse them.
- Add to bsg_manycore_pkg: the 2-bit npa_class_e enum {e_npa_dram, e_npa_tile_group, e_npa_global, e_npa_invalid}.
- One sub-module: bsg_manycore_dram_hash_inverse, a combinational DRAM detection and word-index builder. It mirrors bsg_manycore_dram_hash_function.

## Test plan
Common configuration: x_cord 7, y_cord 7, 16×8 tiles (x_sub 4, y_sub 3), pod_x 3, pod_y 4, block 8, addr 28, pod_x_i=1, pod_y_i=1.

- DRAM north: x=19, y=7, epa=0x25 → eva_o=0x80001074 at t+2, invalid=0.
- Global, foreign pod: x=5, y=9, epa=0x123 → eva_o=0x4485048C.
- Tile-group: tgo=(1,2), x=20, y=11, epa=0x40 → tile_group_addr_s fields x=3, y=1, addr=0x40, remote=001.
- Invalid: x=5, y=9, epa=2^14 → eva_o=0, is_invalid_addr_o=1.
  - Repeat 70000 times: invalid_count_o saturates at 0xFFFF.
- Backpressure: stream 10 NPAs with yumi_i toggling randomly → outputs in order, none dropped or duplicated, ready_o=0 only when both stages are full and yumi_i=0.
- Reset with both stages full → v_o=0 and invalid_count_o=0 immediately. The first post-reset input emerges at t+2.
